bwt_rotation_loader: RTL and testbench
======================================

// Module: bwt_rotation_loader
// PURPOSE
// - Upstream feeder of the merge-sort stage in the BWT datapath.
// - Accepts one input string as a byte stream (valid/ready) into a STRING_LEN x 8 buffer.
// - Builds all STRING_LEN cyclic rotations, each truncated to a COLUMN-byte sort key.
// - Presents the rotations in parallel, pulses start, then holds off the next string
//   until the sorter reports sorted.
// PARAMETERS
// - COLUMN      3  bytes per sort key (rotation prefix length); 1..STRING_LEN
// - STRING_LEN  8  characters per string = rows handed to the sorter; power of 2, >=2
// PORTS
// - clk        in   1                          system clock, rising edge
// - rst        in   1                          asynchronous, active-high reset
// - in_valid   in   1                          in_byte is valid this cycle
// - in_ready   out  1                          loader accepts a byte this cycle
// - in_byte    in   8                          next string character, first char first
// - cfg_sort   in   2                          sort mode; latched with the first byte of a string
// - sort_done  in   1                          sorted level from the merge-sort stage
// - rot_data   out  [COLUMN-1:0][7:0] x STRING_LEN  row r = key of rotation r, to sorter data_in
// - start      out  1                          one-cycle pulse: rot_data valid, sort may begin
// - sort_num   out  2                          latched cfg_sort, stable from start until done
// - busy       out  1                          high from first accepted byte until string retired
// - str_count  out  8                          strings retired since reset, wraps 255->0
// BEHAVIOUR
// - Reset (async assert, sync release): state LOAD, wr_ptr=0.
//   in_ready=1, start=0, busy=0, sort_num=0, str_count=0, rot_data all 0, buffer cleared.
// - FSM states: LOAD -> BUILD -> START -> WAIT -> LOAD.
// - LOAD: in_ready=1.
//   - Byte accept = in_valid & in_ready; stores buf[wr_ptr] <= in_byte, wr_ptr++.
//   - Accept with wr_ptr=0 latches cfg_sort into sort_num and sets busy.
//   - Accept with wr_ptr=STRING_LEN-1 wraps wr_ptr to 0 and goes to BUILD.
//   - in_valid=0 in LOAD is a stall: no state change, partial string retained.
// - BUILD (1 cycle): in_ready=0.
//   - rot_data[r][COLUMN-1-c] <= buf[(r+c) mod STRING_LEN], for r<STRING_LEN, c<COLUMN.
//   - First character sits in the MS byte, so an unsigned key compare is lexicographic.
//   - Index arithmetic is $clog2(STRING_LEN) bits with natural wrap; no modulo divider.
// - START (1 cycle): start=1, in_ready=0.
//   - Latency: last byte accepted in cycle N -> start high in cycle N+2.
// - WAIT: in_ready=0. rot_data and sort_num held constant.
//   - Exit on a rising edge of sort_done (registered prev sample); a level already high
//     on entry is ignored.
//   - On exit: busy<=0, str_count++, back to LOAD.
// - in_valid while in_ready=0: ignored, no byte lost (source holds per valid/ready).
// - Reset mid-string or mid-WAIT: partial string discarded, all outputs to reset values
//   immediately; start never glitches high.
// - cfg_sort changes mid-string: no effect until the next string's first byte.
// STRUCTURE
// - Shared package bwt_pkg: typedef byte_t (logic[7:0]).
// - Shared package bwt_pkg: typedef key_t (byte_t [COLUMN-1:0]).
// - Shared package bwt_pkg: enum loader_state_e {LOAD,BUILD,START,WAIT}.
// - Shared package bwt_pkg: localparam PTR_W = $clog2(STRING_LEN).
// - One sub-module: bwt_rotate_net, purely combinational buf -> rotation keys
//   (generate loops); registered by the loader in BUILD.
// - Everything else lives in this module: FSM, write pointer, edge detect, counters.
// TESTING
// - Reset, then bytes "BANANA$X" (0x42,41,4E,41,4E,41,24,58) back-to-back, cfg_sort=1
//   -> start pulse 2 cycles after last byte; sort_num=1.
//   -> rot_data[0]=0x42414E, rot_data[1]=0x414E41, rot_data[7]=0x584241.
// - Same string with in_valid toggling 1/0 each cycle
//   -> identical rot_data; start exactly 2 cycles after 8th accepted byte.
// - In WAIT: drive in_valid=1 for 20 cycles, then pulse sort_done
//   -> in_ready=0 throughout, buffer unchanged.
//   -> busy falls and str_count 0->1 the cycle after the sort_done edge; in_ready=1 next.
// - sort_done held high on WAIT entry
//   -> no exit until it falls and rises again.
// - Assert rst after 5 bytes, release, send a full new string
//   -> rot_data reflects only the new string; str_count=0 then 1.
// - Retire 256 strings -> str_count wraps to 0.
// - Retire 256 strings with STRING_LEN=4, COLUMN=4
//   -> rotation wrap correct: row 3 = {s3,s0,s1,s2}.

Source files
------------

// File: rtl/bwt_pkg.sv
// Shared types for the BWT datapath: byte/key types, loader FSM states and
// default geometry used when the loader is instantiated without overrides.
package bwt_pkg;

    localparam int unsigned DEF_COLUMN     = 3;
    localparam int unsigned DEF_STRING_LEN = 8;
    localparam int unsigned PTR_W          = $clog2(DEF_STRING_LEN);

    typedef logic [7:0] byte_t;
    typedef byte_t [DEF_COLUMN-1:0] key_t;

    typedef enum logic [1:0] {
        LOAD,
        BUILD,
        START,
        WAIT
    } loader_state_e;

endpackage

// File: rtl/bwt_rotate_net.sv
// Combinational rotation network: row r is the COLUMN-byte prefix of the
// string rotated left by r, first character in the most significant byte.
module bwt_rotate_net
    import bwt_pkg::*;
#(
    parameter int unsigned COLUMN     = DEF_COLUMN,
    parameter int unsigned STRING_LEN = DEF_STRING_LEN
) (
    input  byte_t [STRING_LEN-1:0]             i_buf,
    output byte_t [STRING_LEN-1:0][COLUMN-1:0] o_keys
);

    localparam int unsigned L_PTR_W = $clog2(STRING_LEN);

    for (genvar r = 0; r < STRING_LEN; r++) begin : g_row
        for (genvar c = 0; c < COLUMN; c++) begin : g_col
            // Index wraps by truncation; STRING_LEN is a power of two.
            localparam logic [L_PTR_W-1:0] IDX = L_PTR_W'(r + c);
            assign o_keys[r][COLUMN-1-c] = i_buf[IDX];
        end
    end

endmodule

// File: rtl/bwt_rotation_loader.sv
// Loads one string as a byte stream, registers all cyclic rotation keys,
// pulses start to the merge-sort stage and waits for its sorted edge.
module bwt_rotation_loader
    import bwt_pkg::*;
#(
    parameter int unsigned COLUMN     = DEF_COLUMN,
    parameter int unsigned STRING_LEN = DEF_STRING_LEN
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [7:0]                             in_byte,
    input  logic [1:0]                             cfg_sort,
    input  logic                                   sort_done,
    output logic [STRING_LEN-1:0][COLUMN-1:0][7:0] rot_data,
    output logic                                   start,
    output logic [1:0]                             sort_num,
    output logic                                   busy,
    output logic [7:0]                             str_count
);

    localparam int unsigned        L_PTR_W  = $clog2(STRING_LEN);
    localparam logic [L_PTR_W-1:0] LAST_PTR = L_PTR_W'(STRING_LEN - 1);

    loader_state_e r_state;
    loader_state_e w_next;

    logic [L_PTR_W-1:0]                     r_wr_ptr;
    byte_t [STRING_LEN-1:0]                 r_buf;
    byte_t [STRING_LEN-1:0][COLUMN-1:0]     w_keys;
    logic [STRING_LEN-1:0][COLUMN-1:0][7:0] r_rot;
    logic                                   r_start;
    logic                                   r_busy;
    logic [1:0]                             r_sort_num;
    logic [7:0]                             r_str_count;
    logic                                   r_done_prev;
    logic                                   w_in_ready;
    logic                                   w_accept;
    logic                                   w_done_rise;

    bwt_rotate_net #(
        .COLUMN     (COLUMN),
        .STRING_LEN (STRING_LEN)
    ) u_rotate (
        .i_buf  (r_buf),
        .o_keys (w_keys)
    );

    assign w_accept    = in_valid & w_in_ready;
    assign w_done_rise = sort_done & ~r_done_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        case (r_state)
            LOAD: begin
                w_in_ready = 1'b1;
                if (in_valid && (r_wr_ptr == LAST_PTR)) begin
                    w_next = BUILD;
                end
            end
            BUILD:   w_next = START;
            START:   w_next = WAIT;
            WAIT: begin
                if (w_done_rise) begin
                    w_next = LOAD;
                end
            end
            default: w_next = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_buf       <= '0;
            r_rot       <= '0;
            r_start     <= 1'b0;
            r_busy      <= 1'b0;
            r_sort_num  <= '0;
            r_str_count <= '0;
            r_done_prev <= 1'b0;
        end else begin
            r_done_prev <= sort_done;
            // Registered pulse so start cannot glitch on a state decode.
            r_start     <= (r_state == BUILD);

            if (w_accept) begin
                r_buf[r_wr_ptr] <= in_byte;
                r_wr_ptr        <= r_wr_ptr + L_PTR_W'(1);
                if (r_wr_ptr == '0) begin
                    r_sort_num <= cfg_sort;
                    r_busy     <= 1'b1;
                end
            end

            if (r_state == BUILD) begin
                r_rot <= w_keys;
            end

            if ((r_state == WAIT) && w_done_rise) begin
                r_busy      <= 1'b0;
                r_str_count <= r_str_count + 8'd1;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign rot_data  = r_rot;
    assign start     = r_start;
    assign sort_num  = r_sort_num;
    assign busy      = r_busy;
    assign str_count = r_str_count;

endmodule

// File: tb/tb_bwt_rotation_loader.sv
// Scoreboard bench for bwt_rotation_loader: default 8x3 instance plus a 4x4
// instance; expected rotation keys come from a plain modulo-index model.
module tb_bwt_rotation_loader;
    import bwt_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic             in_valid, in_ready, start, busy, sort_done;
    logic [7:0]       in_byte, str_count;
    logic [1:0]       cfg_sort, sort_num;
    logic [7:0][2:0][7:0] rot_data;

    logic             b_valid, b_ready, b_start, b_busy, b_done;
    logic [7:0]       b_byte, b_count;
    logic [1:0]       b_cfg, b_sort_num;
    logic [3:0][3:0][7:0] b_rot;

    bwt_rotation_loader #(.COLUMN(3), .STRING_LEN(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_byte(in_byte), .cfg_sort(cfg_sort), .sort_done(sort_done),
        .rot_data(rot_data), .start(start), .sort_num(sort_num),
        .busy(busy), .str_count(str_count)
    );

    bwt_rotation_loader #(.COLUMN(4), .STRING_LEN(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready),
        .in_byte(b_byte), .cfg_sort(b_cfg), .sort_done(b_done),
        .rot_data(b_rot), .start(b_start), .sort_num(b_sort_num),
        .busy(b_busy), .str_count(b_count)
    );

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;
    int exp_count = 0;
    logic [191:0] last_exp;

    logic [191:0] q_rot[$];
    logic [1:0]   q_sort[$];
    int           q_cyc[$];
    logic [127:0] q4_rot[$];
    logic [1:0]   q4_sort[$];
    int           q4_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [191:0] got, input logic [191:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [191:0] model8(input logic [7:0] s[8]);
        logic [191:0] k = '0;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 3; c++)
                k |= 192'(s[(r + c) % 8]) << (r * 24 + (2 - c) * 8);
        return k;
    endfunction

    function automatic logic [127:0] model4(input logic [7:0] s[4]);
        logic [127:0] k = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                k |= 128'(s[(r + c) % 4]) << (r * 32 + (3 - c) * 8);
        return k;
    endfunction

    // Monitors: every start pulse must match the oldest expected string.
    always @(negedge clk) begin
        if (!rst && start) begin
            if (q_rot.size() == 0) begin
                check("start_unexpected", 192'(1), 192'(0));
            end else begin
                check("rot_data", 192'(rot_data), q_rot.pop_front());
                check("sort_num", 192'(sort_num), 192'(q_sort.pop_front()));
                check("start_latency", 192'(cyc), 192'(q_cyc.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b_start) begin
            if (q4_rot.size() == 0) begin
                check("b_start_unexpected", 192'(1), 192'(0));
            end else begin
                check("b_rot_data", 192'(b_rot), 192'(q4_rot.pop_front()));
                check("b_sort_num", 192'(b_sort_num), 192'(q4_sort.pop_front()));
                check("b_start_latency", 192'(cyc), 192'(q4_cyc.pop_front()));
            end
        end
    end

    // mode 0: back-to-back, 1: valid toggles 1/0, 2: random gaps
    task automatic send8(input logic [7:0] s[8], input logic [1:0] cfg, input int mode);
        int   i = 0;
        int   guard = 0;
        logic ph = 1'b1;
        logic v;
        while (i < 8 && guard < 200) begin
            @(negedge clk);
            guard++;
            v = (mode == 0) ? 1'b1 : (mode == 1) ? ph : ($urandom_range(0, 2) != 0);
            ph = ~ph;
            in_valid = v;
            in_byte  = v ? s[i] : 8'($urandom);
            cfg_sort = (i == 0) ? cfg : 2'($urandom);
            if (v && in_ready) begin
                if (i == 7) begin
                    last_exp = model8(s);
                    q_rot.push_back(last_exp);
                    q_sort.push_back(cfg);
                    q_cyc.push_back(cyc + 2);
                end
                i++;
            end
        end
        if (i < 8) check("send_timeout", 192'(i), 192'(8));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Called on the first WAIT cycle.
    task automatic retire(input bit garbage, input bit hold);
        check("busy_in_wait", 192'(busy), 192'(1));
        check("ready_in_wait", 192'(in_ready), 192'(0));
        if (garbage) begin
            for (int k = 0; k < 20; k++) begin
                in_valid = 1'b1;
                in_byte  = 8'($urandom);
                @(negedge clk);
                check("ready_held_low", 192'(in_ready), 192'(0));
            end
            in_valid = 1'b0;
            check("rot_held", 192'(rot_data), last_exp);
        end
        if (hold) begin
            repeat (3) @(negedge clk);
            check("hold_no_exit", 192'(busy), 192'(1));
            sort_done = 1'b0;
            @(negedge clk);
            check("fall_no_exit", 192'(busy), 192'(1));
        end
        sort_done = 1'b1;
        @(negedge clk);
        sort_done = 1'b0;
        exp_count = (exp_count + 1) % 256;
        check("busy_after_done", 192'(busy), 192'(0));
        check("str_count", 192'(str_count), 192'(exp_count));
        check("ready_after_done", 192'(in_ready), 192'(1));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] s[8];
        logic [7:0] s4[4];
        logic [1:0] cfg;
        int i, g;

        rst = 1'b1;
        in_valid = 1'b0; in_byte = '0; cfg_sort = '0; sort_done = 1'b0;
        b_valid = 1'b0; b_byte = '0; b_cfg = '0; b_done = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 192'(in_ready), 192'(1));
        check("rst_start", 192'(start), 192'(0));
        check("rst_busy", 192'(busy), 192'(0));
        check("rst_str_count", 192'(str_count), 192'(0));
        check("rst_sort_num", 192'(sort_num), 192'(0));
        check("rst_rot_data", 192'(rot_data), 192'(0));
        rst = 1'b0;
        @(negedge clk);

        s = '{8'h42, 8'h41, 8'h4E, 8'h41, 8'h4E, 8'h41, 8'h24, 8'h58};
        send8(s, 2'd1, 0);
        repeat (2) @(negedge clk);
        check("banana_row0", 192'(rot_data[0]), 192'h42414E);
        check("banana_row1", 192'(rot_data[1]), 192'h414E41);
        check("banana_row7", 192'(rot_data[7]), 192'h584241);
        check("banana_sort_num", 192'(sort_num), 192'(1));
        retire(0, 0);

        send8(s, 2'd1, 1);
        repeat (2) @(negedge clk);
        retire(1, 0);

        foreach (s[k]) s[k] = 8'($urandom);
        sort_done = 1'b1;
        send8(s, 2'd3, 2);
        repeat (2) @(negedge clk);
        retire(0, 1);

        // Reset in the middle of a string.
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_byte  = 8'($urandom);
            cfg_sort = 2'd2;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("busy_partial", 192'(busy), 192'(1));
        #2 rst = 1'b1;
        #1;
        check("arst_in_ready", 192'(in_ready), 192'(1));
        check("arst_start", 192'(start), 192'(0));
        check("arst_busy", 192'(busy), 192'(0));
        check("arst_str_count", 192'(str_count), 192'(0));
        check("arst_sort_num", 192'(sort_num), 192'(0));
        check("arst_rot_data", 192'(rot_data), 192'(0));
        @(negedge clk);
        rst = 1'b0;
        exp_count = 0;
        foreach (s[k]) s[k] = 8'($urandom);
        send8(s, 2'd0, 0);
        repeat (2) @(negedge clk);
        retire(0, 0);

        for (int n = 0; n < 255; n++) begin
            foreach (s[k]) s[k] = 8'($urandom);
            cfg = 2'($urandom);
            send8(s, cfg, ($urandom_range(0, 1) == 0) ? 0 : 2);
            repeat (2) @(negedge clk);
            retire(0, 0);
        end
        check("str_count_wrap", 192'(str_count), 192'(0));

        // 4x4 instance: 256 strings, checks rotation wrap and counter wrap.
        for (int n = 0; n < 256; n++) begin
            if (n == 0) s4 = '{8'h11, 8'h22, 8'h33, 8'h44};
            else foreach (s4[k]) s4[k] = 8'($urandom);
            cfg = 2'($urandom);
            i = 0; g = 0;
            while (i < 4 && g < 50) begin
                @(negedge clk);
                g++;
                b_valid = 1'b1;
                b_byte  = s4[i];
                b_cfg   = (i == 0) ? cfg : 2'($urandom);
                if (b_ready) begin
                    if (i == 3) begin
                        q4_rot.push_back(model4(s4));
                        q4_sort.push_back(cfg);
                        q4_cyc.push_back(cyc + 2);
                    end
                    i++;
                end
            end
            if (i < 4) check("b_send_timeout", 192'(i), 192'(4));
            @(negedge clk);
            b_valid = 1'b0;
            repeat (2) @(negedge clk);
            if (n == 0) check("b_row3_wrap", 192'(b_rot[3]), 192'h44112233);
            check("b_busy_wait", 192'(b_busy), 192'(1));
            b_done = 1'b1;
            @(negedge clk);
            b_done = 1'b0;
            check("b_busy_done", 192'(b_busy), 192'(0));
            check("b_str_count", 192'(b_count), 192'((n + 1) % 256));
        end
        check("b_str_count_wrap", 192'(b_count), 192'(0));

        repeat (3) @(negedge clk);
        check("pending_starts", 192'(q_rot.size() + q4_rot.size()), 192'(0));

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
